// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID->EX control unit. It decodes the ID opcode and registers the control
// bundle into EX. It also handles the load-use interlock, MUL occupancy, redirect
// flush, illegal-opcode flagging and a saturating stall counter.
module ctrl_pipe #(
    parameter int unsigned OPW     = 4,
    parameter int unsigned RAW     = 5,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [OPW-1:0]  id_op,
    input  logic [RAW-1:0]  id_rs,
    input  logic [RAW-1:0]  id_rt,
    input  logic [RAW-1:0]  id_wa,
    input  logic            ex_redirect,
    output logic            ex_valid,
    output logic            ex_wen,
    output logic            ex_branch,
    output logic            ex_mem_to_reg,
    output logic            ex_mem_write,
    output logic            ex_mem_read,
    output logic            ex_alusrc,
    output logic            ex_regdst,
    output logic            ex_jr,
    output logic            ex_jump,
    output logic            ex_jal,
    output logic            ex_illegal,
    output logic [2:0]      ex_aluop,
    output logic [RAW-1:0]  ex_wa,
    output logic            ex_busy,
    output logic            illegal_seen,
    output logic [CNTW-1:0] stall_cnt
);

    localparam int unsigned MCW = 4;

    typedef enum logic [0:0] {RUN = 1'b0, MWAIT = 1'b1} state_t;

    typedef struct packed {
        logic           valid;
        logic           wen;
        logic           branch;
        logic           mem_to_reg;
        logic           mem_write;
        logic           mem_read;
        logic           alusrc;
        logic           regdst;
        logic           jr;
        logic           jump;
        logic           jal;
        logic           illegal;
        logic [2:0]     aluop;
        logic [RAW-1:0] wa;
        logic           busy;
    } ex_t;

    state_t          state_q, state_d;
    logic [MCW-1:0]  mcnt_q, mcnt_d;
    ex_t             ex_q, ex_d, dec;
    logic            ill_q, ill_d;
    logic [CNTW-1:0] stall_q, stall_d;
    logic [3:0]      op;
    logic            upper_bad;
    logic            uses_rt;
    logic            hz;

    assign op        = id_op[3:0];
    assign upper_bad = (id_op >> 4) != '0;

    // Opcode decode into the EX control bundle; a MUL longer than one cycle starts busy.
    always_comb begin
        dec     = '0;
        uses_rt = 1'b0;
        if (upper_bad || op >= 4'd14) begin
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
        end else begin
            dec.valid      = 1'b1;
            dec.wa         = id_wa;
            dec.wen        = (op <= 4'd8) || (op == 4'd12);
            dec.aluop      = (op <= 4'd7) ? op[2:0] : ((op == 4'd10) ? 3'd1 : 3'd0);
            dec.branch     = op == 4'd10;
            dec.mem_to_reg = op == 4'd8;
            dec.mem_read   = op == 4'd8;
            dec.mem_write  = op == 4'd9;
            dec.alusrc     = (op == 4'd4) || (op == 4'd5) || (op == 4'd8) || (op == 4'd9);
            dec.regdst     = (op == 4'd9) || (op == 4'd10);
            dec.jr         = op == 4'd13;
            dec.jump       = (op == 4'd11) || (op == 4'd12);
            dec.jal        = op == 4'd12;
            uses_rt        = (op <= 4'd3) || (op == 4'd6) || (op == 4'd7) ||
                             (op == 4'd9) || (op == 4'd10);
            if (op == 4'd7 && MUL_LAT > 1) begin
                dec.wen  = 1'b0;
                dec.busy = 1'b1;
            end
        end
    end

    // Load-use hazard against a load sitting in EX.
    always_comb begin
        hz = ex_q.valid && ex_q.mem_read && (ex_q.wa != '0) &&
             ((ex_q.wa == id_rs) || (uses_rt && (ex_q.wa == id_rt)));
    end

    assign id_ready = (state_q == RUN) && !hz && !ex_redirect;

    // Next-state, EX bundle, sticky illegal and stall counter.
    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        ex_d    = ex_q;
        ill_d   = ill_q | (ex_q.valid & ex_q.illegal);
        stall_d = stall_q;
        if (id_valid && !id_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNTW'(1);
        end
        if (ex_redirect) begin
            ex_d    = '0;
            state_d = RUN;
            mcnt_d  = '0;
        end else if (state_q == MWAIT) begin
            if (mcnt_q <= MCW'(1)) begin
                state_d   = RUN;
                mcnt_d    = '0;
                ex_d.wen  = 1'b1;
                ex_d.busy = 1'b0;
            end else begin
                mcnt_d = mcnt_q - MCW'(1);
            end
        end else if (hz) begin
            ex_d = '0;
        end else if (id_valid) begin
            ex_d = dec;
            if (dec.busy) begin
                state_d = MWAIT;
                mcnt_d  = MCW'(MUL_LAT - 1);
            end
        end else begin
            ex_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            mcnt_q  <= '0;
            ex_q    <= '0;
            ill_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            ex_q    <= ex_d;
            ill_q   <= ill_d;
            stall_q <= stall_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_wen        = ex_q.wen;
    assign ex_branch     = ex_q.branch;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_alusrc     = ex_q.alusrc;
    assign ex_regdst     = ex_q.regdst;
    assign ex_jr         = ex_q.jr;
    assign ex_jump       = ex_q.jump;
    assign ex_jal        = ex_q.jal;
    assign ex_illegal    = ex_q.illegal;
    assign ex_aluop      = ex_q.aluop;
    assign ex_wa         = ex_q.wa;
    assign ex_busy       = ex_q.busy;
    assign illegal_seen  = ill_q;
    assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: an instruction-level model checked every cycle, plus directed literals.
module tb_ctrl_pipe;

    localparam int MUL_LAT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       id_valid = 1'b0;
    logic [3:0] id_op = '0;
    logic [4:0] id_rs = '0, id_rt = '0, id_wa = '0;
    logic       ex_redirect = 1'b0;

    logic id_ready, ex_valid, ex_wen, ex_branch, ex_mem_to_reg, ex_mem_write, ex_mem_read;
    logic ex_alusrc, ex_regdst, ex_jr, ex_jump, ex_jal, ex_illegal, ex_busy, illegal_seen;
    logic [2:0] ex_aluop;
    logic [4:0] ex_wa;
    logic [15:0] stall_cnt;

    logic id_ready2, ex_valid2, ex_wen2, ex_branch2, ex_mem_to_reg2, ex_mem_write2, ex_mem_read2;
    logic ex_alusrc2, ex_regdst2, ex_jr2, ex_jump2, ex_jal2, ex_illegal2, ex_busy2, illegal_seen2;
    logic [2:0] ex_aluop2;
    logic [4:0] ex_wa2;
    logic [1:0] stall_cnt2;

    ctrl_pipe #(.OPW(4), .RAW(5), .MUL_LAT(MUL_LAT), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_wa(id_wa), .ex_redirect(ex_redirect),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_branch(ex_branch), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read), .ex_alusrc(ex_alusrc),
        .ex_regdst(ex_regdst), .ex_jr(ex_jr), .ex_jump(ex_jump), .ex_jal(ex_jal),
        .ex_illegal(ex_illegal), .ex_aluop(ex_aluop), .ex_wa(ex_wa), .ex_busy(ex_busy),
        .illegal_seen(illegal_seen), .stall_cnt(stall_cnt));

    ctrl_pipe #(.OPW(4), .RAW(5), .MUL_LAT(MUL_LAT), .CNTW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready2), .id_op(id_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_wa(id_wa), .ex_redirect(ex_redirect),
        .ex_valid(ex_valid2), .ex_wen(ex_wen2), .ex_branch(ex_branch2), .ex_mem_to_reg(ex_mem_to_reg2),
        .ex_mem_write(ex_mem_write2), .ex_mem_read(ex_mem_read2), .ex_alusrc(ex_alusrc2),
        .ex_regdst(ex_regdst2), .ex_jr(ex_jr2), .ex_jump(ex_jump2), .ex_jal(ex_jal2),
        .ex_illegal(ex_illegal2), .ex_aluop(ex_aluop2), .ex_wa(ex_wa2), .ex_busy(ex_busy2),
        .illegal_seen(illegal_seen2), .stall_cnt(stall_cnt2));

    always #5 clk = ~clk;

    logic [21:0] vec1, vec2;
    assign vec1 = {ex_valid, ex_wen, ex_branch, ex_mem_to_reg, ex_mem_write, ex_mem_read, ex_alusrc,
                   ex_regdst, ex_jr, ex_jump, ex_jal, ex_illegal, ex_aluop, ex_wa, ex_busy, illegal_seen};
    assign vec2 = {ex_valid2, ex_wen2, ex_branch2, ex_mem_to_reg2, ex_mem_write2, ex_mem_read2, ex_alusrc2,
                   ex_regdst2, ex_jr2, ex_jump2, ex_jal2, ex_illegal2, ex_aluop2, ex_wa2, ex_busy2, illegal_seen2};

    int n_checks = 0;
    int n_err = 0;

    // Model: which instruction occupies EX and for how long (op = -1 means illegal).
    logic m_valid = 1'b0;
    int   m_op = 0;
    logic [4:0] m_wa = '0;
    int   m_age = 0;
    logic m_ill = 1'b0;
    int   m_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_busy();
        return m_valid && (m_op == 7) && (MUL_LAT > 1) && (m_age < MUL_LAT - 1);
    endfunction

    function automatic logic m_hz();
        int o;
        logic rt_used;
        o = int'(id_op);
        rt_used = o inside {0, 1, 2, 3, 6, 7, 9, 10};
        return m_valid && (m_op == 8) && (m_wa != 0) &&
               ((m_wa == id_rs) || (rt_used && (m_wa == id_rt)));
    endfunction

    function automatic logic m_ready();
        return !m_busy() && !m_hz() && !ex_redirect;
    endfunction

    function automatic logic [21:0] exp_vec();
        logic [11:0] c;
        logic [2:0]  alu;
        logic [4:0]  wa;
        logic        busy;
        int          o;
        c = '0; alu = '0; wa = '0; busy = 1'b0; o = m_op;
        if (m_valid) begin
            if (o < 0) begin
                c = 12'b1000_0000_0001;
            end else begin
                c[11] = 1'b1;
                c[10] = (o <= 8) || (o == 12);
                c[9]  = o == 10;
                c[8]  = o == 8;
                c[7]  = o == 9;
                c[6]  = o == 8;
                c[5]  = o inside {4, 5, 8, 9};
                c[4]  = o inside {9, 10};
                c[3]  = o == 13;
                c[2]  = o inside {11, 12};
                c[1]  = o == 12;
                alu   = (o <= 7) ? 3'(o) : ((o == 10) ? 3'd1 : 3'd0);
                wa    = m_wa;
                if (o == 7 && MUL_LAT > 1) begin
                    busy  = m_age < MUL_LAT - 1;
                    c[10] = !busy;
                end
            end
        end
        return {c, alu, wa, busy, m_ill};
    endfunction

    // Per-cycle compare at the falling edge, then advance the model to the next rising edge.
    initial begin
        logic rdy;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_valid = 1'b0; m_op = 0; m_wa = '0; m_age = 0; m_ill = 1'b0; m_stall = 0;
            end
            chk("bundle", 32'(vec1), 32'(exp_vec()));
            chk("id_ready", 32'(id_ready), 32'(m_ready()));
            chk("stall_cnt", 32'(stall_cnt), 32'((m_stall > 65535) ? 65535 : m_stall));
            chk("bundle2", 32'(vec2), 32'(exp_vec()));
            chk("stall_cnt2", 32'(stall_cnt2), 32'((m_stall > 3) ? 3 : m_stall));
            if (rst_n) begin
                rdy = m_ready();
                if (id_valid && !rdy) m_stall++;
                if (m_valid && m_op < 0) m_ill = 1'b1;
                if (ex_redirect) begin
                    m_valid = 1'b0;
                end else if (m_busy()) begin
                    m_age++;
                end else if (id_valid && rdy) begin
                    m_valid = 1'b1;
                    m_age   = 0;
                    if (id_op >= 4'd14) begin
                        m_op = -1; m_wa = '0;
                    end else begin
                        m_op = int'(id_op); m_wa = id_wa;
                    end
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int op, input int rs, input int rt, input int wa);
        id_valid = v;
        id_op    = 4'(op);
        id_rs    = 5'(rs);
        id_rt    = 5'(rt);
        id_wa    = 5'(wa);
    endtask

    // Directed scenarios with hand-computed literal expectations.
    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_vec", 32'(vec1), 32'h0);
        chk("rst_ready", 32'(id_ready), 32'h1);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // Decode sweep, one op per cycle; idle while a MUL drains.
        for (int op = 0; op < 14; op++) begin
            drive(1'b1, op, 0, 0, op + 1);
            step();
            if (op == 8) begin
                chk("lw_wen", 32'(ex_wen), 32'h1);
                chk("lw_aluop", 32'(ex_aluop), 32'h0);
                chk("lw_mem_read", 32'(ex_mem_read), 32'h1);
                chk("lw_mem_to_reg", 32'(ex_mem_to_reg), 32'h1);
                chk("lw_alusrc", 32'(ex_alusrc), 32'h1);
            end
            if (op == 10) chk("beq_aluop", 32'(ex_aluop), 32'h1);
            for (int k = 0; k < 8 && ex_busy; k++) begin
                drive(1'b0, 0, 0, 0, 0);
                step();
            end
            chk("drain_busy", 32'(ex_busy), 32'h0);
        end

        // Load-use on rs stalls one cycle.
        drive(1'b1, 8, 0, 0, 5);
        step();
        drive(1'b1, 0, 5, 0, 3);
        #1 chk("lu_ready", 32'(id_ready), 32'h0);
        step();
        chk("lu_bubble", 32'(ex_valid), 32'h0);
        chk("lu_stall", 32'(stall_cnt), 32'h1);
        chk("lu_ready_after", 32'(id_ready), 32'h1);
        step();
        chk("lu_add_valid", 32'(ex_valid), 32'h1);
        chk("lu_add_wa", 32'(ex_wa), 32'h3);

        // SLL does not read rt: no stall.
        drive(1'b1, 8, 0, 0, 5);
        step();
        drive(1'b1, 4, 0, 5, 2);
        #1 chk("sll_ready", 32'(id_ready), 32'h1);
        step();
        chk("sll_alusrc", 32'(ex_alusrc), 32'h1);
        chk("sll_stall", 32'(stall_cnt), 32'h1);

        // MUL occupancy with an ADD waiting.
        drive(1'b1, 7, 1, 2, 4);
        step();
        chk("mul1_busy", 32'(ex_busy), 32'h1);
        chk("mul1_wen", 32'(ex_wen), 32'h0);
        drive(1'b1, 0, 0, 0, 6);
        #1 chk("mul1_ready", 32'(id_ready), 32'h0);
        step();
        chk("mul2_busy", 32'(ex_busy), 32'h1);
        chk("mul2_ready", 32'(id_ready), 32'h0);
        step();
        chk("mul3_busy", 32'(ex_busy), 32'h0);
        chk("mul3_wen", 32'(ex_wen), 32'h1);
        chk("mul3_ready", 32'(id_ready), 32'h1);
        step();
        chk("mul_next_wa", 32'(ex_wa), 32'h6);
        chk("mul_stall", 32'(stall_cnt), 32'h3);

        // Redirect drops the SUB in ID.
        drive(1'b1, 10, 0, 0, 0);
        step();
        drive(1'b1, 1, 0, 0, 7);
        ex_redirect = 1'b1;
        #1 chk("redir_ready", 32'(id_ready), 32'h0);
        step();
        ex_redirect = 1'b0;
        chk("redir_bubble", 32'(ex_valid), 32'h0);
        chk("redir_stall", 32'(stall_cnt), 32'h4);

        // Redirect during MWAIT.
        drive(1'b1, 7, 0, 0, 4);
        step();
        drive(1'b0, 0, 0, 0, 0);
        ex_redirect = 1'b1;
        step();
        ex_redirect = 1'b0;
        #1;
        chk("redir_mw_busy", 32'(ex_busy), 32'h0);
        chk("redir_mw_valid", 32'(ex_valid), 32'h0);
        chk("redir_mw_ready", 32'(id_ready), 32'h1);

        // Illegal opcode.
        drive(1'b1, 14, 0, 0, 9);
        step();
        chk("ill_valid", 32'(ex_valid), 32'h1);
        chk("ill_flag", 32'(ex_illegal), 32'h1);
        chk("ill_wen", 32'(ex_wen), 32'h0);
        chk("ill_seen_early", 32'(illegal_seen), 32'h0);
        drive(1'b0, 0, 0, 0, 0);
        step();
        chk("ill_seen", 32'(illegal_seen), 32'h1);
        step();
        chk("ill_seen_sticky", 32'(illegal_seen), 32'h1);

        // Two load-use stalls, then one MUL stall: stall_cnt reaches 7 mid-MUL.
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 8, 0, 0, 5);
            step();
            drive(1'b1, 0, 5, 0, 3);
            step();
            step();
        end
        drive(1'b1, 7, 0, 0, 4);
        step();
        drive(1'b1, 0, 0, 0, 6);
        step();
        chk("pre_rst_stall", 32'(stall_cnt), 32'h7);
        chk("pre_rst_busy", 32'(ex_busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_vec", 32'(vec1), 32'h0);
        chk("async_rst_stall", 32'(stall_cnt), 32'h0);
        chk("async_rst_ready", 32'(id_ready), 32'h1);
        step();
        rst_n = 1'b1;

        // Held stall for 5 cycles saturates the 2-bit counter.
        ex_redirect = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("sat_stall16", 32'(stall_cnt), 32'h5);
        chk("sat_stall2", 32'(stall_cnt2), 32'h3);
        ex_redirect = 1'b0;
        drive(1'b0, 0, 0, 0, 0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined, parametrised control unit placed between the decode (ID) and execute (EX) stages of the core. It decodes the ID-stage opcode into the control bundle and registers that bundle into the EX stage. It also handles load-use interlock, multi-cycle MUL occupancy, redirect flush and illegal-opcode flagging, and it keeps a saturating stall counter.

## Interface
- OPW, 4: opcode width (≥4); only id_op[3:0] is decoded, upper bits must be 0 else illegal.
- RAW, 5: register address width.
- MUL_LAT, 3: cycles a MUL occupies EX (1..15).
- CNTW, 16: stall counter width.

- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- id_valid  in  1  ID holds an instruction.
- id_ready  out  1  ID instruction accepted this cycle (combinational).
- id_op  in  OPW  opcode.
- id_rs, id_rt, id_wa  in  RAW  source and destination register addresses.
- ex_redirect  in  1  taken branch/jump resolved in EX; flush.
- ex_valid, ex_wen, ex_branch, ex_mem_to_reg, ex_mem_write, ex_mem_read, ex_alusrc, ex_regdst, ex_jr, ex_jump, ex_jal, ex_illegal  out  1 each  registered control bundle.
- ex_aluop  out  3  registered ALU op.
- ex_wa  out  RAW  registered destination.
- ex_busy  out  1  multi-cycle MUL in progress (registered).
- illegal_seen  out  1  sticky; cleared only by reset.
- stall_cnt  out  CNTW  saturating count of stall cycles.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 SLL, 5 SRL, 6 COM, 7 MUL, 8 LW, 9 SW, 10 BEQ, 11 J, 12 JAL, 13 JR. Codes 14, 15 and any nonzero upper bit are illegal.
- wen is 1 for ops 0-8 and 12; otherwise 0.
- aluop is op[2:0] for ops 0-7, 0 (ADD) for LW and SW, 1 (SUB) for BEQ, and 0 for all other ops.
- Remaining decode fields:
  - branch: BEQ only.
  - mem_to_reg and mem_read: LW only.
  - mem_write: SW only.
  - alusrc: SLL, SRL, LW, SW.
  - regdst: SW, BEQ.
  - jr: JR only.
  - jump: J, JAL.
  - jal: JAL only.
- Illegal opcode: captured with ex_valid=1, ex_illegal=1 and all other control bits 0. illegal_seen sets on the following edge.
- uses_rt is 1 for ops 0-3, 6, 7, 9 and 10.
- Load-use hazard, hz, is true when all of the following hold:
  - ex_valid and ex_mem_read are 1;
  - ex_wa ≠ 0;
  - ex_wa == id_rs, or (uses_rt and ex_wa == id_rt).
- States:
  - RUN: the normal state.
  - MWAIT: entered when a MUL is captured with MUL_LAT>1; the down-counter mcnt is loaded with MUL_LAT-1.
- id_ready = state==RUN && !hz && !ex_redirect.
- Each cycle, exactly one of the following applies, in priority order:
  1. ex_redirect: the EX register becomes a bubble (all ex_* = 0), the ID instruction is dropped, state goes to RUN and mcnt is cleared.
  2. MWAIT: the EX register is held. When mcnt reaches 1, the next cycle returns to RUN and the final MUL cycle asserts ex_wen.
  3. hz: a bubble is inserted into EX and ID is held.
  4. id_valid && id_ready: the decoded bundle is captured.
  5. Otherwise: a bubble is inserted.
- During a MUL in MWAIT: ex_wen=0 and ex_busy=1 on every EX cycle except the final one. The final cycle has ex_wen=1 and ex_busy=0. With MUL_LAT=1 a MUL behaves as a single-cycle op.
- stall_cnt increments on each cycle where id_valid=1 and id_ready=0, and saturates at all-ones.

## Timing
- Decode-to-EX latency is 1 cycle: the bundle appears the cycle after the id_valid && id_ready edge.
- id_ready is combinational from state, hz and ex_redirect. There is no combinational path from id_op to any ex_* output.
- Load-use stall lasts exactly 1 cycle. The bubble clears hz on the next cycle.
- MUL occupies EX for exactly MUL_LAT cycles. id_ready is low for MUL_LAT-1 cycles.
- A redirect takes effect in the same cycle: id_ready=0 and EX is a bubble on the next edge.
- Reset state:
  - Every ex_*, ex_busy, illegal_seen and stall_cnt is 0.
  - State is RUN and mcnt is 0.
  - id_ready is 1.
- Asserting rst_n low mid-MUL or mid-stall clears everything immediately, with no clock required.

## Test plan
- Decode sweep: ops 0-13 each with id_valid=1 and no hazards → each bundle matches the decode rules one cycle later. Example: LW gives wen=1, aluop=0, mem_read=1, mem_to_reg=1, alusrc=1.
- Load-use: LW with id_wa=5, then ADD with id_rs=5 → id_ready=0 for 1 cycle, EX bubble, stall_cnt=1, then ADD is captured. Repeat with rt=5 on SLL (which does not use rt) → no stall.
- MUL with MUL_LAT=3 → ex_busy=1 for 2 cycles, id_ready=0 for 2 cycles, ex_wen=1 only in the 3rd cycle. The next ADD is captured in cycle 4.
- Redirect: BEQ in EX with ex_redirect=1 while SUB is in ID → SUB is dropped and EX holds a bubble. Redirect asserted during MWAIT → state returns to RUN and ex_busy=0.
- Illegal: op=14 → ex_valid=1, ex_illegal=1, wen=0, and illegal_seen=1 stays set until reset.
- Reset: drop rst_n mid-MUL with stall_cnt=7 → all outputs 0 asynchronously and id_ready=1. Separately, with CNTW=2, hold a stall 5 cycles → stall_cnt saturates at 3.
